// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// The FSM state encoding and the default no-op word live here so RAM, loader and bench agree.
package imem_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] NOP_INSTR_DEFAULT = 8'h00;

endpackage

// File: rtl/imem_loader_ram.sv
// Program store: 2**ADDR_W bytes, synchronous write, asynchronous read, no reset.
// Contents survive reloads and resets; the loader masks stale data with its byte count.
module imem_ram #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [7:0]        wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [7:0]        rdata_o
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_loader.sv
// Streams a program into the instruction RAM, then releases the processor and serves fetches.
// state | meaning: IDLE - waiting for first load; LOAD - accepting bytes; RUN - processor executing.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [7:0]        instr,
  output logic              cpu_run,
  output logic              load_done,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_error
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     ld_count_q, ld_count_d;
  logic                ld_error_q, ld_error_d;
  logic                load_done_q, load_done_d;

  logic                ram_we;
  logic [7:0]          ram_rdata;
  logic                addr_full;
  logic                fetch_ok;

  imem_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (ld_data),
    .raddr_i (pc),
    .rdata_o (ram_rdata)
  );

  assign addr_full = (wr_addr_q == {ADDR_W{1'b1}});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_addr_q   <= '0;
      ld_count_q  <= '0;
      ld_error_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      ld_count_q  <= ld_count_d;
      ld_error_q  <= ld_error_d;
      load_done_q <= load_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_addr_d   = wr_addr_q;
    ld_count_d  = ld_count_q;
    ld_error_d  = ld_error_q;
    load_done_d = 1'b0;
    ram_we      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          wr_addr_d  = '0;
          ld_count_d = '0;
          ld_error_d = 1'b0;
        end
      end
      ST_LOAD: begin
        // A restart wins over a coincident byte, which is dropped.
        if (load_start) begin
          wr_addr_d  = '0;
          ld_count_d = '0;
          ld_error_d = 1'b0;
        end else if (ld_valid) begin
          ram_we     = 1'b1;
          wr_addr_d  = wr_addr_q + ADDR_ONE;
          ld_count_d = ld_count_q + CNT_ONE;
          if (ld_last || addr_full) begin
            state_d     = ST_RUN;
            load_done_d = 1'b1;
            if (!ld_last) begin
              ld_error_d = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        if (load_start) begin
          state_d    = ST_LOAD;
          wr_addr_d  = '0;
          ld_count_d = '0;
          ld_error_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Widen pc by one bit so a full-depth program validates every address.
  assign fetch_ok  = (state_q == ST_RUN) && ({1'b0, pc} < ld_count_q);

  assign instr     = fetch_ok ? ram_rdata : NOP_INSTR;
  assign ld_ready  = (state_q == ST_LOAD);
  assign cpu_run   = (state_q == ST_RUN);
  assign load_done = load_done_q;
  assign ld_count  = ld_count_q;
  assign ld_error  = ld_error_q;

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: program-memory address width; depth is 2**ADDR_W.
REQ-002 Parameter NOP_INSTR, default 8'h00: instruction word driven whenever no valid program byte is presented.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 load_start  input  1  request (re)load of program from address 0.
REQ-006 ld_valid  input  1  ld_data holds a program byte.
REQ-007 ld_data  input  8  program byte.
REQ-008 ld_last  input  1  qualifies ld_data as final byte of program.
REQ-009 ld_ready  output  1  block accepts a byte this cycle.
REQ-010 pc  input  ADDR_W  fetch address from processor.
REQ-011 instr  output  8  instruction word to processor.
REQ-012 cpu_run  output  1  processor may execute; low while idle or loading.
REQ-013 load_done  output  1  one-cycle pulse when a load completes.
REQ-014 ld_count  output  ADDR_W+1  number of bytes stored by the most recent load.
REQ-015 ld_error  output  1  sticky overflow flag for the current load.

Function
REQ-016 FSM states: IDLE, LOAD, RUN; encoding is registered state only.
REQ-017 IDLE -> LOAD on load_start; otherwise remain IDLE.
REQ-018 LOAD: ld_ready = 1; byte transferred when ld_valid & ld_ready on a rising edge, written to address wr_addr, wr_addr and ld_count increment by 1.
REQ-019 LOAD -> RUN on transfer with ld_last = 1, or on transfer at wr_addr = 2**ADDR_W-1 (full).
REQ-020 Transfer at full address with ld_last = 0: byte stored, ld_error set, transition to RUN.
REQ-021 load_start while in LOAD: restart; wr_addr and ld_count cleared to 0, ld_error cleared, any byte presented that cycle is not stored, remain LOAD.
REQ-022 RUN -> LOAD on load_start; wr_addr, ld_count, ld_error cleared; cpu_run low from the next cycle.
REQ-023 Outside LOAD: ld_ready = 0; ld_valid ignored.
REQ-024 load_done pulses high for exactly the one cycle after the LOAD -> RUN edge (i.e. first cycle in RUN).
REQ-025 cpu_run = 1 iff state is RUN.
REQ-026 instr is combinational, zero-latency from pc: mem[pc] when state = RUN and pc < ld_count; NOP_INSTR otherwise.
REQ-027 pc comparison is unsigned, widened to ADDR_W+1 bits; with ld_count = 2**ADDR_W every pc is valid.
REQ-028 Memory contents are retained across reload until overwritten; reads above ld_count still return NOP_INSTR.
REQ-029 Zero-length load impossible: LOAD exits only on a transfer, so ld_count >= 1 in RUN.

Reset
REQ-030 Reset asserted: state = IDLE, wr_addr = 0, ld_count = 0, ld_error = 0, load_done = 0, cpu_run = 0, ld_ready = 0, instr = NOP_INSTR, immediately and asynchronously.
REQ-031 Reset mid-load abandons the load; memory array is not cleared; ld_count = 0 masks all contents.

Structure
REQ-032 Shared package holds FSM state enumeration and NOP_INSTR default constant.
REQ-033 One sub-module imem_ram: 2**ADDR_W x 8, one synchronous write port, one asynchronous read port, no reset.
REQ-034 imem_loader contains FSM, address/count registers, handshake, instr masking.

Verification
REQ-035 Reset, load_start, stream 8'h11,8'h22,8'h33 (last on 8'h33) back-to-back -> load_done pulses once, ld_count = 3, cpu_run = 1; pc 0/1/2/3 -> instr 11/22/33/00.
REQ-036 Stream with ld_valid gaps of 2 idle cycles between bytes -> only valid bytes stored, ld_count = 4, contents in order.
REQ-037 Stream 256 bytes, ld_last never asserted -> ld_error = 1, ld_count = 256, RUN entered after byte 256, pc 8'hFF returns byte 256.
REQ-038 load_start asserted coincident with 3rd byte in LOAD -> that byte not stored, ld_count = 0, next byte lands at address 0.
REQ-039 In RUN with 5-byte program, load_start then 2-byte reload -> cpu_run low during LOAD, instr = 00 during LOAD, after reload pc 2 -> 00 despite retained old data.
REQ-040 reset asserted mid-stream between clock edges -> all outputs at reset values before next edge, state IDLE, ld_ready = 0.
